cruise_control_core: RTL and testbench

Parametrised second-generation cruise-control core: a tick-paced speed and setpoint engine with an engage/override/alert state machine. New over the first generation:
- configurable widths, limits and step sizes;
- edge-latched buttons, so short presses between ticks are not lost;
- brake-suspend with a resume-to-previous-setpoint function;
- a minimum engage speed.

It sits between the debounced pedal/switch/sensor inputs and the separate 7-segment/LED display decoders.

---
 rtl/cruise_control_core.sv | 207 ++++++++++++++++++++
 tb/tb_cruise_control_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cruise_control_core.sv
// Tick-paced cruise-control core: edge-latched buttons, engage/override/alert FSM,
// saturating speed and setpoint arithmetic. All outputs are registered.
module cruise_control_core #(
  parameter int SPEED_W    = 7,
  parameter int MAX_SPEED  = 64,
  parameter int MIN_SET    = 20,
  parameter int TICK_DIV   = 12500000,
  parameter int ACC_STEP   = 1,
  parameter int DEC_STEP   = 1,
  parameter int BRAKE_STEP = 2,
  parameter int COAST_STEP = 1,
  parameter int ALERT_STEP = 3,
  parameter int SET_STEP   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               accelerator,
  input  logic               brake,
  input  logic               cc_en,
  input  logic               add,
  input  logic               sub,
  input  logic               resume,
  input  logic               too_close,
  input  logic               approaching_object,
  output logic [SPEED_W-1:0] cur_speed,
  output logic [SPEED_W-1:0] set_speed,
  output logic [2:0]         state,
  output logic               cc_active,
  output logic               alert,
  output logic               saved_valid
);

  localparam int W1    = SPEED_W + 1;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef logic [W1-1:0]      wide_t;
  typedef logic [SPEED_W-1:0] spd_t;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_HOLD     = 3'd1,
    S_ACCEL    = 3'd2,
    S_DECEL    = 3'd3,
    S_OVERRIDE = 3'd4,
    S_ALERT    = 3'd5
  } state_e;

  localparam wide_t MAX_W   = wide_t'(MAX_SPEED);
  localparam wide_t MIN_W   = wide_t'(MIN_SET);
  localparam wide_t ACC_W   = wide_t'(ACC_STEP);
  localparam wide_t DEC_W   = wide_t'(DEC_STEP);
  localparam wide_t BRAKE_W = wide_t'(BRAKE_STEP);
  localparam wide_t COAST_W = wide_t'(COAST_STEP);
  localparam wide_t ALERT_W = wide_t'(ALERT_STEP);
  localparam wide_t SET_W   = wide_t'(SET_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam int E_ADD = 0;
  localparam int E_SUB = 1;
  localparam int E_RES = 2;
  localparam int E_EN  = 3;

  // Widened add/subtract with clamping; neither can wrap.
  function automatic spd_t sat_up(spd_t a, wide_t step);
    wide_t s;
    s = wide_t'(a) + step;
    return (s > MAX_W) ? spd_t'(MAX_W) : spd_t'(s);
  endfunction

  function automatic spd_t sat_dn(spd_t a, wide_t step, wide_t floor_v);
    if (wide_t'(a) < floor_v + step) return spd_t'(floor_v);
    return spd_t'(wide_t'(a) - step);
  endfunction

  function automatic wide_t min_w(wide_t a, wide_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic state_e regulate(spd_t cur, spd_t set, logic close);
    if (close || cur > set) return S_DECEL;
    if (cur < set)          return S_ACCEL;
    return S_HOLD;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [3:0]       btn, prev_q, flag_q, flag_d, evt;
  state_e           state_q, state_d;
  spd_t             cur_q, cur_d, set_q, set_d, set_adj;
  logic             saved_q, saved_d;
  logic             cc_active_q, cc_active_d, alert_q, alert_d;
  logic             do_reg;
  wide_t            gap_up, gap_dn;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // An edge landing in the tick cycle is seen through evt and consumed at once.
  assign btn    = {cc_en, resume, sub, add};
  assign evt    = flag_q | (btn & ~prev_q);
  assign flag_d = tick ? '0 : evt;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
    state_d = state_q;
    cur_d   = cur_q;
    set_d   = set_q;
    saved_d = saved_q;
    set_adj = set_q;
    do_reg  = 1'b0;
    gap_up  = '0;
    gap_dn  = '0;
    if (tick) begin
      case (state_q)
        S_OFF: begin
          if (evt[E_EN] && !brake && cur_q >= spd_t'(MIN_W)) begin
            state_d = S_HOLD;
            set_adj = cur_q;
            saved_d = 1'b0;
          end else if (evt[E_RES] && cc_en && saved_q && !brake) begin
            state_d = S_HOLD;
          end
        end
        S_HOLD, S_ACCEL, S_DECEL: begin
          if (!cc_en)                                 begin state_d = S_OFF; saved_d = 1'b0; end
          else if (brake)                             begin state_d = S_OFF; saved_d = 1'b1; end
          else if (approaching_object && !accelerator) state_d = S_ALERT;
          else if (accelerator)                       state_d = S_OVERRIDE;
          else                                        do_reg  = 1'b1;
        end
        S_OVERRIDE: begin
          if (!cc_en)            begin state_d = S_OFF; saved_d = 1'b0; end
          else if (brake)        begin state_d = S_OFF; saved_d = 1'b1; end
          else if (!accelerator) do_reg = 1'b1;
        end
        S_ALERT: begin
          if (!cc_en)                   begin state_d = S_OFF; saved_d = 1'b0; end
          else if (brake)               begin state_d = S_OFF; saved_d = 1'b1; end
          else if (accelerator)         state_d = S_OVERRIDE;
          else if (!approaching_object) do_reg = 1'b1;
        end
        default: state_d = S_OFF;
      endcase

      // The adjusted setpoint is what the regulator and speed update see this tick.
      if (state_d != S_OFF) begin
        if (evt[E_ADD] && !evt[E_SUB])      set_adj = sat_up(set_adj, SET_W);
        else if (evt[E_SUB] && !evt[E_ADD]) set_adj = sat_dn(set_adj, SET_W, MIN_W);
      end
      set_d = set_adj;
      if (do_reg) state_d = regulate(cur_q, set_adj, too_close);

      gap_up = (set_adj > cur_q) ? wide_t'(set_adj) - wide_t'(cur_q) : '0;
      gap_dn = (cur_q > set_adj) ? wide_t'(cur_q) - wide_t'(set_adj) : '0;

      case (state_d)
        S_OFF: begin
          if (brake)            cur_d = sat_dn(cur_q, BRAKE_W, '0);
          else if (accelerator) cur_d = sat_up(cur_q, ACC_W);
          else                  cur_d = sat_dn(cur_q, COAST_W, '0);
        end
        S_ACCEL:    cur_d = sat_up(cur_q, min_w(ACC_W, gap_up));
        S_DECEL:    cur_d = too_close ? sat_dn(cur_q, DEC_W, '0)
                                      : sat_dn(cur_q, min_w(DEC_W, gap_dn), '0);
        S_OVERRIDE: if (accelerator) cur_d = sat_up(cur_q, ACC_W);
        S_ALERT:    cur_d = sat_dn(cur_q, ALERT_W, '0);
        default:    cur_d = cur_q;
      endcase
    end
  end

  assign cc_active_d = (state_d inside {S_HOLD, S_ACCEL, S_DECEL, S_ALERT});
  assign alert_d     = (state_d == S_ALERT);

  // NOTE: sequential state is assigned non-blocking so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      prev_q      <= '0;
      flag_q      <= '0;
      state_q     <= S_OFF;
      cur_q       <= '0;
      set_q       <= '0;
      saved_q     <= 1'b0;
      cc_active_q <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prev_q      <= btn;
      flag_q      <= flag_d;
      state_q     <= state_d;
      cur_q       <= cur_d;
      set_q       <= set_d;
      saved_q     <= saved_d;
      cc_active_q <= cc_active_d;
      alert_q     <= alert_d;
    end
  end

  assign cur_speed   = cur_q;
  assign set_speed   = set_q;
  assign state       = state_q;
  assign cc_active   = cc_active_q;
  assign alert       = alert_q;
  assign saved_valid = saved_q;

endmodule

// File: tb/tb_cruise_control_core.sv
// Bench for cruise_control_core at TICK_DIV=4: directed scenarios then random ticks,
// every tick compared against a tick-level behavioural model.
module tb_cruise_control_core;

  localparam int SPEED_W = 7;
  localparam int MAX_SPD = 64;
  localparam int MIN_SET = 20;
  localparam int ACC     = 1;
  localparam int DEC     = 1;
  localparam int BRK     = 2;
  localparam int COAST   = 1;
  localparam int ALRT    = 3;
  localparam int SSTEP   = 1;

  localparam int S_OFF = 0, S_HOLD = 1, S_ACCEL = 2, S_DECEL = 3, S_OVR = 4, S_ALERT = 5;

  logic clk = 1'b0;
  logic rst_n, acc, brk, en, add, sub, res, tc, ao;
  logic [SPEED_W-1:0] cur_speed, set_speed;
  logic [2:0] state;
  logic cc_active, alert, saved_valid;

  int checks = 0;
  int errors = 0;

  int m_cur, m_set, m_state;
  bit m_saved, m_en_prev;

  bit r_acc, r_brk, r_en, r_tc, r_ao, r_add, r_sub, r_res, r_gl;

  cruise_control_core #(.SPEED_W(SPEED_W), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .accelerator(acc), .brake(brk), .cc_en(en),
    .add(add), .sub(sub), .resume(res), .too_close(tc), .approaching_object(ao),
    .cur_speed(cur_speed), .set_speed(set_speed), .state(state),
    .cc_active(cc_active), .alert(alert), .saved_valid(saved_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
  function automatic int clamp(int v);       return imin(imax(v, 0), MAX_SPD); endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), m_state);
    check({tag, ".cur"},   32'(cur_speed), m_cur);
    check({tag, ".set"},   32'(set_speed), m_set);
    check({tag, ".saved"}, 32'(saved_valid), 32'(m_saved));
    check({tag, ".active"}, 32'(cc_active),
          32'(m_state == S_HOLD || m_state == S_ACCEL || m_state == S_DECEL || m_state == S_ALERT));
    check({tag, ".alert"}, 32'(alert), 32'(m_state == S_ALERT));
  endtask

  task automatic model_reset();
    m_cur = 0; m_set = 0; m_state = S_OFF; m_saved = 0; m_en_prev = 0;
  endtask

  // One update tick, straight from the behavioural rules with integer arithmetic.
  task automatic model_tick(input bit a_acc, input bit a_brk, input bit a_en, input bit a_tc,
                            input bit a_ao, input bit e_add, input bit e_sub, input bit e_res,
                            input bit e_rise);
    int  nxt;
    bit  reg_pending;
    reg_pending = 0;
    nxt = m_state;
    if (m_state == S_OFF) begin
      if (e_rise && !a_brk && m_cur >= MIN_SET) begin
        nxt = S_HOLD; m_set = m_cur; m_saved = 0;
      end else if (e_res && a_en && m_saved && !a_brk) nxt = S_HOLD;
    end else if (!a_en) begin nxt = S_OFF; m_saved = 0; end
    else if (a_brk)     begin nxt = S_OFF; m_saved = 1; end
    else if (m_state == S_OVR) reg_pending = !a_acc;
    else if (m_state == S_ALERT) begin
      if (a_acc) nxt = S_OVR;
      else reg_pending = !a_ao;
    end
    else if (a_ao && !a_acc) nxt = S_ALERT;
    else if (a_acc)          nxt = S_OVR;
    else                     reg_pending = 1;

    if (nxt != S_OFF && e_add != e_sub)
      m_set = e_add ? imin(m_set + SSTEP, MAX_SPD) : imax(m_set - SSTEP, MIN_SET);
    if (reg_pending)
      nxt = (a_tc || m_cur > m_set) ? S_DECEL : (m_cur < m_set) ? S_ACCEL : S_HOLD;

    case (nxt)
      S_OFF:   m_cur = clamp(m_cur + (a_brk ? -BRK : (a_acc ? ACC : -COAST)));
      S_ACCEL: m_cur = clamp(m_cur + imin(ACC, m_set - m_cur));
      S_DECEL: m_cur = clamp(m_cur - (a_tc ? DEC : imin(DEC, m_cur - m_set)));
      S_OVR:   m_cur = clamp(m_cur + (a_acc ? ACC : 0));
      S_ALERT: m_cur = clamp(m_cur - ALRT);
      default: ;
    endcase
    m_state = nxt;
  endtask

  // Starts just after a tick edge: levels held for the interval, button pulses
  // one cycle wide in cycle 'slot' (3 = the tick cycle), optional brake glitch in cycle 2.
  task automatic do_tick(input bit a_acc, input bit a_brk, input bit a_en, input bit a_tc,
                         input bit a_ao, input bit a_add, input bit a_sub, input bit a_res,
                         input int slot, input bit glitch, input string tag);
    bit rise;
    rise = a_en && !m_en_prev;
    acc = a_acc; brk = a_brk; en = a_en; tc = a_tc; ao = a_ao;
    for (int c = 0; c < 4; c++) begin
      if (c == slot) begin add = a_add; sub = a_sub; res = a_res; end
      if (glitch && c == 2) brk = !a_brk;
      @(posedge clk); #1;
      add = 0; sub = 0; res = 0; brk = a_brk;
    end
    model_tick(a_acc, a_brk, a_en, a_tc, a_ao, a_add, a_sub, a_res, rise);
    m_en_prev = a_en;
    check_all(tag);
  endtask

  // Engaged-mode shorthand: cc_en high, pulses in cycle 1.
  task automatic t_on(input bit a_acc, input bit a_brk, input bit a_tc, input bit a_ao,
                      input bit a_add, input bit a_sub, input bit a_res, input string tag);
    do_tick(a_acc, a_brk, 1'b1, a_tc, a_ao, a_add, a_sub, a_res, 1, 1'b0, tag);
  endtask

  initial begin
    rst_n = 0; acc = 0; brk = 0; en = 0; add = 0; sub = 0; res = 0; tc = 0; ao = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.cur", 32'(cur_speed), 0);
    check("rst.set", 32'(set_speed), 0);
    check("rst.state", 32'(state), S_OFF);
    check("rst.flags", {29'd0, cc_active, alert, saved_valid}, 0);
    rst_n = 1;

    // Engage below minimum, then a valid engage at 25.
    for (int k = 0; k < 30 && m_cur < 15; k++) do_tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "ramp15");
    do_tick(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "low_engage");
    check("low_engage.lit", 32'(state), S_OFF);
    for (int k = 0; k < 30 && m_cur < 25; k++) do_tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "ramp25");
    do_tick(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, "engage");
    check("engage.state.lit", 32'(state), S_HOLD);
    check("engage.set.lit", 32'(set_speed), 25);
    check("engage.active.lit", 32'(cc_active), 1);

    // Setpoint adjust and regulation.
    t_on(0, 0, 0, 0, 1, 0, 0, "add1");
    check("add1.set.lit", 32'(set_speed), 26);
    check("add1.state.lit", 32'(state), S_ACCEL);
    check("add1.cur.lit", 32'(cur_speed), 26);
    t_on(0, 0, 0, 0, 0, 0, 0, "settle26");
    check("settle26.lit", 32'(state), S_HOLD);
    t_on(0, 0, 0, 0, 1, 1, 0, "addsub");
    check("addsub.lit", 32'(set_speed), 26);
    for (int k = 0; k < 60 && m_set < 64; k++) t_on(0, 0, 0, 0, 1, 0, 0, "add_up");
    do_tick(0, 0, 1, 0, 0, 1, 0, 0, 3, 0, "add_max");
    check("add_max.lit", 32'(set_speed), 64);
    for (int k = 0; k < 60 && m_set > 20; k++) do_tick(0, 0, 1, 0, 0, 0, 1, 0, 3, 0, "sub_dn");
    t_on(0, 0, 0, 0, 0, 1, 0, "sub_min");
    check("sub_min.lit", 32'(set_speed), 20);
    for (int k = 0; k < 20 && m_set < 30; k++) t_on(0, 0, 0, 0, 1, 0, 0, "add30");
    for (int k = 0; k < 100 && !(m_state == S_HOLD && m_cur == 30); k++)
      t_on(0, 0, 0, 0, 0, 0, 0, "settle30");
    check("hold30.lit", 32'(cur_speed), 30);

    // Brake, coast with a brake glitch, resume.
    t_on(0, 1, 0, 0, 0, 0, 0, "brake");
    check("brake.state.lit", 32'(state), S_OFF);
    check("brake.saved.lit", 32'(saved_valid), 1);
    check("brake.cur.lit", 32'(cur_speed), 28);
    for (int k = 0; k < 10 && m_cur > 24; k++) do_tick(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, "coast");
    t_on(0, 0, 0, 0, 0, 0, 1, "resume");
    check("resume.state.lit", 32'(state), S_HOLD);
    check("resume.set.lit", 32'(set_speed), 30);
    repeat (6) t_on(0, 0, 0, 0, 0, 0, 0, "reaccel");
    check("reaccel.cur.lit", 32'(cur_speed), 30);
    t_on(0, 0, 0, 0, 0, 0, 0, "rehold");
    check("rehold.lit", 32'(state), S_HOLD);

    // Alert and override.
    t_on(0, 0, 0, 1, 0, 0, 0, "alert1");
    check("alert1.lit", 32'(cur_speed), 27);
    check("alert1.flag.lit", 32'(alert), 1);
    t_on(0, 0, 0, 1, 0, 0, 0, "alert2");
    t_on(0, 0, 0, 1, 0, 0, 0, "alert3");
    check("alert3.lit", 32'(cur_speed), 21);
    t_on(0, 0, 0, 0, 0, 0, 0, "alert_exit");
    check("alert_exit.lit", 32'(state), S_ACCEL);
    for (int k = 0; k < 20 && m_state != S_HOLD; k++) t_on(0, 0, 0, 0, 0, 0, 0, "recover");
    t_on(1, 0, 0, 1, 0, 0, 0, "ovr");
    check("ovr.state.lit", 32'(state), S_OVR);
    check("ovr.alert.lit", 32'(alert), 0);
    t_on(0, 0, 0, 0, 0, 0, 0, "ovr_exit");
    check("ovr_exit.lit", 32'(state), S_DECEL);

    // Saturation at both ends.
    for (int k = 0; k < 40 && m_cur > 1; k++) t_on(0, 0, 1, 0, 0, 0, 0, "close_dn");
    t_on(0, 0, 1, 0, 0, 0, 0, "close_zero");
    check("close_zero.lit", 32'(cur_speed), 0);
    t_on(0, 0, 1, 0, 0, 0, 0, "close_zero2");
    check("close_zero2.lit", 32'(cur_speed), 0);
    for (int k = 0; k < 80 && m_cur < 64; k++) t_on(1, 0, 0, 0, 0, 0, 0, "ovr_up");
    t_on(1, 0, 0, 0, 0, 0, 0, "ovr_max");
    check("ovr_max.lit", 32'(cur_speed), 64);
    for (int k = 0; k < 5 && (m_state == S_OVR || m_cur % 3 != 2); k++)
      t_on(0, 0, 1, 0, 0, 0, 0, "align");
    for (int k = 0; k < 30 && m_cur > 2; k++) t_on(0, 0, 0, 1, 0, 0, 0, "alert_dn");
    t_on(0, 0, 0, 1, 0, 0, 0, "alert_zero");
    check("alert_zero.lit", 32'(cur_speed), 0);

    // Asynchronous reset mid-interval while accelerating.
    t_on(0, 0, 0, 0, 0, 0, 0, "to_accel");
    check("to_accel.lit", 32'(state), S_ACCEL);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 0; en = 0;
    model_reset();
    #1;
    check("arst.cur.lit", 32'(cur_speed), 0);
    check("arst.set.lit", 32'(set_speed), 0);
    check("arst.state.lit", 32'(state), S_OFF);
    check("arst.flags.lit", {29'd0, cc_active, alert, saved_valid}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; acc = 1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("arst.early%0d", c), 32'(cur_speed), 0);
    end
    @(posedge clk); #1;
    model_tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("arst.first_tick.lit", 32'(cur_speed), 1);
    check_all("arst.first_tick");

    // Random ticks against the model.
    for (int n = 0; n < 300; n++) begin
      r_en  = ($urandom_range(0, 99) < 85);
      r_acc = ($urandom_range(0, 99) < ((m_state == S_OFF) ? 70 : 25));
      r_brk = ($urandom_range(0, 99) < 6);
      r_tc  = ($urandom_range(0, 99) < 15);
      r_ao  = ($urandom_range(0, 99) < 12);
      r_add = ($urandom_range(0, 99) < 25);
      r_sub = ($urandom_range(0, 99) < 25);
      r_res = ($urandom_range(0, 99) < 25);
      r_gl  = ($urandom_range(0, 99) < 10);
      do_tick(r_acc, r_brk, r_en, r_tc, r_ao, r_add, r_sub, r_res,
              int'($urandom_range(0, 3)), r_gl, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
